rcon_stream: RTL and testbench

Sequential AES round-constant generator, the clocked, parametrised successor of the combinational `rcon` lookup. It computes round constants on the fly by GF(2^8) doubling and streams them to the key-expansion datapath over a valid/ready handshake. The word is replicated across `LANES` SIMD lanes. Mode selects the AES-128/192/256 sequence length. A registered random-access read port, backed by a `DEPTH`-entry table, is kept for existing `rcon` users.

---
 rtl/rcon_stream_if.sv | 22 ++
 rtl/rcon_stream.sv | 63 ++++++
 tb/tb_rcon_stream.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rcon_stream_if.sv
// rcon_stream_if: stream, control and table-read signals of rcon_stream.
interface rcon_stream_if #(parameter int BITS = 32, parameter int LANES = 4);
  logic start;
  logic [1:0] mode;
  logic out_valid;
  logic out_ready;
  logic [LANES*BITS-1:0] out_word;
  logic [3:0] out_index;
  logic busy;
  logic done;
  logic err;
  logic [7:0] rd_addr;
  logic [BITS-1:0] rd_data;
  modport master(
    input start, mode, out_ready, rd_addr,
    output out_valid, out_word, out_index, busy, done, err, rd_data
  );
  modport slave(
    output start, mode, out_ready, rd_addr,
    input out_valid, out_word, out_index, busy, done, err, rd_data
  );
endinterface

// File: rtl/rcon_stream.sv
// rcon_stream: streams AES round constants by GF(2^8) doubling, plus a registered lookup table.
module rcon_stream #(
  parameter int BITS = 32,
  parameter int LANES = 4,
  parameter int DEPTH = 64
) (
  input logic clk,
  input logic rst,
  rcon_stream_if.master bus
);
  localparam logic [0:0] IDLE = 1'b0, RUN = 1'b1;
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] rc_at(input int n);
    logic [7:0] x;
    x = 8'h01;
    for (int k = 0; k < n; k++) x = xtime(x);
    return x;
  endfunction
  logic [0:0] state;
  logic [7:0] rc;
  logic [3:0] idx, last;
  logic hs;
  logic [BITS-1:0] word;
  logic [7:0] tbl [256];
  // Full 8-bit address space is tabulated; entries at or beyond DEPTH read as zero.
  for (genvar i = 0; i < 256; i++) begin : g_tbl
    assign tbl[i] = i < DEPTH ? rc_at(i) : 8'h00;
  end
  assign hs = state == RUN && bus.out_ready;
  assign word = BITS'(rc) << (BITS - 8);
  assign bus.out_word = {LANES{word}};
  assign bus.out_valid = state == RUN;
  assign bus.busy = state == RUN;
  assign bus.out_index = idx;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      rc <= 8'h00;
      idx <= 4'd0;
      last <= 4'd0;
      bus.done <= 1'b0;
      bus.err <= 1'b0;
      bus.rd_data <= '0;
    end else begin
      bus.done <= hs && idx == last;
      bus.err <= state == IDLE && bus.start && bus.mode == 2'd3;
      bus.rd_data <= BITS'(tbl[bus.rd_addr]) << (BITS - 8);
      if (state == IDLE && bus.start && bus.mode != 2'd3) begin
        state <= RUN;
        rc <= 8'h01;
        idx <= 4'd0;
        last <= bus.mode == 2'd0 ? 4'd9 : bus.mode == 2'd1 ? 4'd7 : 4'd6;
      end else if (hs) begin
        if (idx == last) state <= IDLE;
        else begin
          rc <= xtime(rc);
          idx <= idx + 4'd1;
        end
      end
    end
endmodule

// File: tb/tb_rcon_stream.sv
// tb_rcon_stream: randomized self-checking bench for rcon_stream against a doubling model.
module tb_rcon_stream;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  rcon_stream_if #(.BITS(32), .LANES(4)) bus();
  rcon_stream #(.BITS(32), .LANES(4), .DEPTH(64)) dut(.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int fails = 0;
  int rd_prev = 0;

  // n-th round constant by repeated doubling modulo x^8+x^4+x^3+x+1, placed in the top byte.
  function automatic logic [31:0] rc_model(input int n);
    int x;
    if (n >= 64) return 32'h0;
    x = 1;
    for (int k = 0; k < n; k++) begin
      x = x * 2;
      if (x > 255) x = (x - 256) ^ 'h1b;
    end
    return 32'(x) << 24;
  endfunction

  function automatic logic [127:0] lanes(input logic [31:0] w);
    return {4{w}};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Consumes words k0..n-1 from a running sequence, checking each plus reads issued meanwhile.
  task automatic drain(input int n, input int k0, input bit rnd, input string tag);
    int k;
    int budget;
    bit rdy;
    k = k0;
    budget = 400;
    while (k < n && budget > 0) begin
      budget--;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.done !== 1'b0 || bus.out_index !== 4'(k) || bus.out_word !== lanes(rc_model(k))) begin
        fails++;
        $display("FAIL %s word %0d: valid=%b done=%b index=%0d word=%h, required valid=1 done=0 index=%0d word=%h",
                 tag, k, bus.out_valid, bus.done, bus.out_index, bus.out_word, k, lanes(rc_model(k)));
      end
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.out_ready = rdy;
      bus.start = 1'($urandom_range(0, 1));
      bus.mode = 2'($urandom_range(0, 3));
      rd_prev = $urandom_range(0, 80);
      bus.rd_addr = 8'(rd_prev);
      step;
      checks++;
      if (bus.rd_data !== rc_model(rd_prev)) begin
        fails++;
        $display("FAIL %s read during run addr %0d: got %h, required %h", tag, rd_prev, bus.rd_data, rc_model(rd_prev));
      end
      if (rdy) k++;
    end
    bus.start = 1'b0;
    bus.out_ready = 1'b0;
    checks++;
    if (budget == 0) begin
      fails++;
      $display("FAIL %s timeout: got %0d words, required %0d", tag, k, n);
    end else if (bus.done !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
                 bus.out_index !== 4'(n - 1) || bus.out_word !== lanes(rc_model(n - 1))) begin
      fails++;
      $display("FAIL %s end: done=%b valid=%b busy=%b index=%0d word=%h, required done=1 valid=0 busy=0 index=%0d word=%h",
               tag, bus.done, bus.out_valid, bus.busy, bus.out_index, bus.out_word, n - 1, lanes(rc_model(n - 1)));
    end
  endtask

  task automatic issue(input logic [1:0] m);
    bus.mode = m;
    bus.start = 1'b1;
    step;
    bus.start = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s idle: done=%b busy=%b valid=%b, required 0 0 0", tag, bus.done, bus.busy, bus.out_valid);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.rd_addr = 8'd1;
    step;
    rst = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
      fails++;
      $display("FAIL reset flags: valid=%b busy=%b done=%b err=%b, required all 0", bus.out_valid, bus.busy, bus.done, bus.err);
    end
    checks++;
    if (bus.out_word !== 128'h0 || bus.out_index !== 4'd0 || bus.rd_data !== 32'h0) begin
      fails++;
      $display("FAIL reset data: word=%h index=%0d rd_data=%h, required 0 0 0", bus.out_word, bus.out_index, bus.rd_data);
    end
  endtask

  task automatic test_mode(input logic [1:0] m, input int n);
    issue(m);
    drain(n, 0, 1'b1, $sformatf("mode%0d", m));
    step;
    check_idle($sformatf("mode%0d after done", m));
  endtask

  task automatic test_backpressure;
    int b;
    issue(2'd0);
    bus.out_ready = 1'b1;
    b = 50;
    while (bus.out_index !== 4'd4 && b > 0) begin
      step;
      b--;
    end
    bus.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_index !== 4'd4 || bus.out_word !== lanes(32'h10000000)) begin
        fails++;
        $display("FAIL backpressure hold %0d: valid=%b index=%0d word=%h, required 1 4 %h",
                 c, bus.out_valid, bus.out_index, bus.out_word, lanes(32'h10000000));
      end
    end
    bus.out_ready = 1'b1;
    step;
    checks++;
    if (bus.out_index !== 4'd5 || bus.out_word !== lanes(32'h20000000)) begin
      fails++;
      $display("FAIL backpressure resume: index=%0d word=%h, required 5 %h", bus.out_index, bus.out_word, lanes(32'h20000000));
    end
    drain(10, 5, 1'b0, "backpressure");
    step;
    check_idle("backpressure after done");
  endtask

  task automatic test_illegal;
    issue(2'd3);
    checks++;
    if (bus.err !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL illegal mode: err=%b valid=%b busy=%b, required 1 0 0", bus.err, bus.out_valid, bus.busy);
    end
    step;
    checks++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL illegal mode pulse: err=%b busy=%b, required 0 0", bus.err, bus.busy);
    end
  endtask

  task automatic test_mid_reset;
    int b;
    issue(2'd0);
    bus.out_ready = 1'b1;
    b = 50;
    while (bus.out_index !== 4'd5 && b > 0) begin
      step;
      b--;
    end
    rst = 1'b1;
    step;
    rst = 1'b0;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_word !== 128'h0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL mid reset: valid=%b word=%h done=%b busy=%b, required 0 0 0 0", bus.out_valid, bus.out_word, bus.done, bus.busy);
    end
    step;
    check_idle("mid reset next");
    issue(2'd0);
    drain(10, 0, 1'b1, "restart");
    step;
  endtask

  task automatic test_random_access;
    int addrs [7] = '{0, 1, 2, 3, 8, 9, 64};
    logic [31:0] exp [7] = '{32'h01000000, 32'h02000000, 32'h04000000, 32'h08000000,
                             32'h1B000000, 32'h36000000, 32'h00000000};
    int a;
    for (int i = 0; i < 7; i++) begin
      bus.rd_addr = 8'(addrs[i]);
      step;
      checks++;
      if (bus.rd_data !== exp[i]) begin
        fails++;
        $display("FAIL read addr %0d: got %h, required %h", addrs[i], bus.rd_data, exp[i]);
      end
    end
    for (int i = 0; i < 20; i++) begin
      a = $urandom_range(0, 255);
      bus.rd_addr = 8'(a);
      step;
      checks++;
      if (bus.rd_data !== rc_model(a)) begin
        fails++;
        $display("FAIL random read addr %0d: got %h, required %h", a, bus.rd_data, rc_model(a));
      end
    end
  endtask

  task automatic test_back_to_back;
    issue(2'd2);
    drain(7, 0, 1'b0, "b2b first");
    issue(2'd1);
    checks++;
    if (bus.done !== 1'b0 || bus.out_valid !== 1'b1 || bus.busy !== 1'b1 ||
        bus.out_index !== 4'd0 || bus.out_word !== lanes(32'h01000000)) begin
      fails++;
      $display("FAIL b2b restart: done=%b valid=%b busy=%b index=%0d word=%h, required 0 1 1 0 %h",
               bus.done, bus.out_valid, bus.busy, bus.out_index, bus.out_word, lanes(32'h01000000));
    end
    drain(8, 0, 1'b1, "b2b second");
    step;
    check_idle("b2b after done");
  endtask

  initial begin
    bus.start = 1'b0;
    bus.mode = 2'd0;
    bus.out_ready = 1'b0;
    bus.rd_addr = 8'd0;
    test_reset;
    test_mode(2'd0, 10);
    test_mode(2'd1, 8);
    test_mode(2'd2, 7);
    test_backpressure;
    test_illegal;
    test_mid_reset;
    test_random_access;
    test_back_to_back;
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
